// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
// Shared constants and types for the two-master sram_a arbiter.
//   - reset / enable polarities used on the sram_a control pins
//   - ownership state encodings (IDLE, OWN0, OWN1)
//   - read-tag record carried down the read-return pipeline
package sram_arbiter_pkg;

  localparam logic RST_ENABLE    = 1'b0;
  localparam logic RST_DISABLE   = 1'b1;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Ownership state that corresponds to a given master id.
  function automatic logic [1:0] own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/sram_arbiter_rd_tag_pipe.sv
// sram_arbiter_rd_tag_pipe
// RD_LAT-deep {valid,id} shift register that follows each read issued to
// sram_a and raises the issuing master's rvalid in the cycle its data
// appears on sram_rdata.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   issue_valid  a read command is on the sram_a pins this cycle (sram_re)
//   issue_id     master that owns that read
//   m0_rvalid    read data on sram_rdata belongs to master 0
//   m1_rvalid    read data on sram_rdata belongs to master 1
module sram_arbiter_rd_tag_pipe
  import sram_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_valid,
  input  logic issue_id,
  output logic m0_rvalid,
  output logic m1_rvalid
);

  rd_tag_t stage [RD_LAT];

  // Stage 0 captures the read at the end of its sram_re cycle, so the last
  // stage lines up with the cycle sram_rdata is valid. Reset drops every
  // in-flight tag so no stale rvalid escapes after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= {issue_valid, issue_id};
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign m0_rvalid = stage[RD_LAT-1].valid & ~stage[RD_LAT-1].id;
  assign m1_rvalid = stage[RD_LAT-1].valid &  stage[RD_LAT-1].id;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one sram_a (clkr/clkw tied to clk) between two masters with a
// round-robin grant and an optional bounded lock for bursts.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mN_req/we/lock/addr/wdata  master N command (held until acked)
//   mN_ack                   command accepted this cycle (combinational)
//   mN_rvalid                m_rdata carries master N's read data
//   m_rdata                  shared read data (sram_rdata passed through)
//   sram_*                   registered sram_a control/address/data pins
//   sram_rdata               sram_a read data
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  sram_ce,
  output logic                  sram_re,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [1:0]            state, state_next;
  logic [HOLD_W-1:0]     hold_cnt, hold_next, hold_inc;
  logic                  rr_ptr;
  logic                  sel_valid, sel_id;
  logic                  owner_active, owner_id, owner_req;
  logic                  xfer;
  logic                  xfer_we, xfer_lock;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic                  rd_id;

  assign owner_active = (state == OWN0) || (state == OWN1);
  assign owner_id     = (state == OWN1);
  assign owner_req    = owner_id ? m1_req : m0_req;

  // Grant selection. A requesting owner always wins; once the owner lets
  // its req drop, normal arbitration applies in that same cycle so the
  // other master is not stalled. rr_ptr names the master that wins a tie.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = rr_ptr;
    if (owner_active && owner_req) begin
      sel_valid = 1'b1;
      sel_id    = owner_id;
    end else if (m0_req && m1_req) begin
      sel_valid = 1'b1;
      sel_id    = rr_ptr;
    end else if (m0_req) begin
      sel_valid = 1'b1;
      sel_id    = 1'b0;
    end else if (m1_req) begin
      sel_valid = 1'b1;
      sel_id    = 1'b1;
    end
  end

  assign m0_ack = (rst == RST_DISABLE) && sel_valid && !sel_id && m0_req;
  assign m1_ack = (rst == RST_DISABLE) && sel_valid &&  sel_id && m1_req;
  assign xfer   = m0_ack || m1_ack;

  assign xfer_we    = sel_id ? m1_we    : m0_we;
  assign xfer_lock  = sel_id ? m1_lock  : m0_lock;
  assign xfer_addr  = sel_id ? m1_addr  : m0_addr;
  assign xfer_wdata = sel_id ? m1_wdata : m0_wdata;

  // Ownership tracking. hold_inc is the beat count including the beat being
  // accepted now; reaching MAX_HOLD forces release regardless of lock.
  always_comb begin
    if (state == own_state(sel_id)) begin
      hold_inc = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + HOLD_ONE;
    end else begin
      hold_inc = HOLD_ONE;
    end

    state_next = state;
    hold_next  = hold_cnt;
    if (xfer) begin
      if (xfer_lock && (hold_inc < HOLD_MAX)) begin
        state_next = own_state(sel_id);
        hold_next  = hold_inc;
      end else begin
        state_next = IDLE;
        hold_next  = '0;
      end
    end else if (owner_active && !owner_req) begin
      state_next = IDLE;
      hold_next  = '0;
    end
  end

  // Command issue. Each accepted command becomes a one-cycle re/we pulse on
  // the next cycle; addresses and write data hold their last value between
  // commands. rd_id remembers who issued the read currently on the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      rr_ptr     <= 1'b0;
      sram_ce    <= 1'b0;
      sram_re    <= READ_DISABLE;
      sram_we    <= WRITE_DISABLE;
      sram_raddr <= '0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      rd_id      <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      sram_ce  <= CHIP_ENABLE;
      if (xfer) begin
        rr_ptr     <= ~sel_id;
        sram_we    <= xfer_we ? WRITE_ENABLE : WRITE_DISABLE;
        sram_re    <= xfer_we ? READ_DISABLE : READ_ENABLE;
        sram_raddr <= xfer_addr;
        sram_waddr <= xfer_addr;
        sram_wdata <= xfer_we ? xfer_wdata : '0;
        rd_id      <= sel_id;
      end else begin
        sram_we <= WRITE_DISABLE;
        sram_re <= READ_DISABLE;
      end
    end
  end

  sram_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (sram_re),
    .issue_id    (rd_id),
    .m0_rvalid   (m0_rvalid),
    .m1_rvalid   (m1_rvalid)
  );

  assign m_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Self-checking bench for sram_arbiter: directed sequences, a table of
// arbitration vectors, and randomized traffic against a transaction-level
// model of the arbiter plus a behavioural sram_a.
module tb_sram_arbiter;

  localparam int AW       = 4;
  localparam int DW       = 8;
  localparam int RD_LAT   = 1;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock, m0_ack, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_lock, m1_ack, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m_rdata;
  logic          sram_ce, sram_re, sram_we;
  logic [AW-1:0] sram_raddr, sram_waddr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LAT     (RD_LAT),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_lock    (m0_lock),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_ack     (m0_ack),
    .m0_rvalid  (m0_rvalid),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_lock    (m1_lock),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_ack     (m1_ack),
    .m1_rvalid  (m1_rvalid),
    .m_rdata    (m_rdata),
    .sram_ce    (sram_ce),
    .sram_re    (sram_re),
    .sram_we    (sram_we),
    .sram_raddr (sram_raddr),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural sram_a: synchronous write, read data RD_LAT cycles after re.
  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (sram_we) mem[sram_waddr] <= sram_wdata;
    rd_pipe[0] <= mem[sram_raddr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign sram_rdata = rd_pipe[RD_LAT-1];

  // Transaction-level reference: who owns the bus, how many beats it has
  // had, who wins the next tie, the expected pin state for the next cycle,
  // a shadow memory, and a queue of reads waiting to come back.
  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       rdq[$];
  logic [DW-1:0] ref_mem [2**AW];
  int            cyc    = 0;
  int            owner  = -1;
  int            beats  = 0;
  int            prefer = 0;
  logic          exp_ce = 1'b0, exp_re = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr  = '0;
  logic [DW-1:0] exp_wdata = '0;
  int            rv0_seen = 0, rv1_seen = 0;
  logic [DW-1:0] last_rdata1 = '0;

  typedef struct {
    logic          req0, we0, lock0;
    logic [AW-1:0] addr0;
    logic          req1, we1, lock1;
    logic [AW-1:0] addr1;
    logic          ea0, ea1;
  } vec_t;

  vec_t vecs [16];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelCheck(output logic a0, output logic a1);
    int            sel;
    logic          we, lk, ev0, ev1;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd, edata;
    a0 = m0_ack;
    a1 = m1_ack;
    cyc++;
    if (m0_rvalid) rv0_seen++;
    if (m1_rvalid) begin
      rv1_seen++;
      last_rdata1 = m_rdata;
    end
    if (rst == 1'b0) begin
      checkOutput("rst_acks", {m0_ack, m1_ack}, 0);
      checkOutput("rst_outputs", {sram_ce, sram_re, sram_we, sram_raddr, sram_waddr,
                                  sram_wdata, m0_rvalid, m1_rvalid}, 0);
      owner = -1; beats = 0; prefer = 0;
      rdq.delete();
      exp_ce = 1'b0; exp_re = 1'b0; exp_we = 1'b0;
      return;
    end

    sel = -1;
    if (owner == 0 && m0_req) sel = 0;
    else if (owner == 1 && m1_req) sel = 1;
    else if (m0_req && m1_req) sel = prefer;
    else if (m0_req) sel = 0;
    else if (m1_req) sel = 1;

    checkOutput("m0_ack", m0_ack, sel == 0);
    checkOutput("m1_ack", m1_ack, sel == 1);
    checkOutput("sram_ce", sram_ce, exp_ce);
    checkOutput("sram_we", sram_we, exp_we);
    checkOutput("sram_re", sram_re, exp_re);
    if (exp_we || exp_re) begin
      checkOutput("sram_raddr", sram_raddr, exp_addr);
      checkOutput("sram_waddr", sram_waddr, exp_addr);
      checkOutput("sram_wdata", sram_wdata, exp_wdata);
    end

    ev0 = 1'b0; ev1 = 1'b0; edata = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      if (rdq[0].id) ev1 = 1'b1; else ev0 = 1'b1;
      edata = rdq[0].data;
      void'(rdq.pop_front());
    end
    checkOutput("m0_rvalid", m0_rvalid, ev0);
    checkOutput("m1_rvalid", m1_rvalid, ev1);
    if (ev0 || ev1) checkOutput("m_rdata", m_rdata, edata);

    exp_ce = 1'b1;
    if (sel >= 0) begin
      we = sel ? m1_we    : m0_we;
      lk = sel ? m1_lock  : m0_lock;
      ad = sel ? m1_addr  : m0_addr;
      wd = sel ? m1_wdata : m0_wdata;
      beats  = (owner == sel) ? beats + 1 : 1;
      prefer = 1 - sel;
      if (lk && beats < MAX_HOLD) owner = sel;
      else begin
        owner = -1;
        beats = 0;
      end
      exp_we    = we;
      exp_re    = !we;
      exp_addr  = ad;
      exp_wdata = we ? wd : '0;
      if (we) ref_mem[ad] = wd;
      else rdq.push_back('{due: cyc + 1 + RD_LAT, id: (sel == 1), data: ref_mem[ad]});
    end else begin
      exp_we = 1'b0;
      exp_re = 1'b0;
      owner  = -1;
      beats  = 0;
    end
  endtask

  task automatic stepCycle(output logic a0, output logic a1);
    @(negedge clk);
    modelCheck(a0, a1);
    @(posedge clk);
    #1;
  endtask

  task automatic idleMasters();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_req = v.req0; m0_we = v.we0; m0_lock = v.lock0; m0_addr = v.addr0; m0_wdata = '0;
    m1_req = v.req1; m1_we = v.we1; m1_lock = v.lock1; m1_addr = v.addr1; m1_wdata = '0;
  endtask

  task automatic applyReset();
    logic a0, a1;
    rst = 1'b0;
    idleMasters();
    stepCycle(a0, a1);
    stepCycle(a0, a1);
    rst = 1'b1;
  endtask

  function automatic vec_t mk(input logic r0, input logic l0, input logic [AW-1:0] ad0,
                              input logic r1, input logic l1, input logic [AW-1:0] ad1,
                              input logic e0, input logic e1);
    vec_t v;
    v.req0 = r0; v.we0 = 1'b0; v.lock0 = l0; v.addr0 = ad0;
    v.req1 = r1; v.we1 = 1'b0; v.lock1 = l1; v.addr1 = ad1;
    v.ea0 = e0; v.ea1 = e1;
    return v;
  endfunction

  initial begin
    logic a0, a1;
    int   rv0_before, rv1_before;

    // Tie round-robin from reset, then m1 locked burst capped at MAX_HOLD,
    // then m0 locked burst released early by dropping req.
    vecs[0]  = mk(1, 0, 4'd1, 1, 0, 4'd2, 1, 0);
    vecs[1]  = mk(1, 0, 4'd1, 1, 0, 4'd2, 0, 1);
    vecs[2]  = mk(1, 0, 4'd1, 1, 0, 4'd2, 1, 0);
    vecs[3]  = mk(1, 0, 4'd1, 1, 0, 4'd2, 0, 1);
    vecs[4]  = mk(0, 0, 4'd3, 1, 1, 4'd4, 0, 1);
    vecs[5]  = mk(1, 0, 4'd3, 1, 1, 4'd4, 0, 1);
    vecs[6]  = mk(1, 0, 4'd3, 1, 1, 4'd4, 0, 1);
    vecs[7]  = mk(1, 0, 4'd3, 1, 1, 4'd4, 0, 1);
    vecs[8]  = mk(1, 0, 4'd3, 1, 1, 4'd4, 1, 0);
    vecs[9]  = mk(1, 0, 4'd6, 1, 1, 4'd4, 0, 1);
    vecs[10] = mk(1, 0, 4'd6, 1, 1, 4'd4, 0, 1);
    vecs[11] = mk(1, 0, 4'd6, 0, 0, 4'd4, 1, 0);
    vecs[12] = mk(1, 1, 4'd7, 0, 0, 4'd8, 1, 0);
    vecs[13] = mk(1, 1, 4'd7, 1, 0, 4'd8, 1, 0);
    vecs[14] = mk(0, 0, 4'd7, 1, 0, 4'd8, 0, 1);
    vecs[15] = mk(0, 0, 4'd7, 0, 0, 4'd8, 0, 0);

    rst = 1'b1;
    idleMasters();
    #1;

    // Reset held 20 ns while m0 is already requesting.
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = '0; m0_wdata = '0;
    stepCycle(a0, a1);
    stepCycle(a0, a1);
    rst = 1'b1;

    // m0 fills the memory with data = addr, one write per cycle.
    for (int a = 0; a < 16; a++) begin
      m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0;
      m0_addr = AW'(a); m0_wdata = DW'(a);
      stepCycle(a0, a1);
      checkOutput($sformatf("wr_ack[%0d]", a), {a0, a1}, 2'b10);
    end

    // m0 reads them back in order.
    rv0_before = rv0_seen;
    rv1_before = rv1_seen;
    for (int a = 0; a < 16; a++) begin
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = AW'(a); m0_wdata = '0;
      stepCycle(a0, a1);
      checkOutput($sformatf("rd_ack[%0d]", a), {a0, a1}, 2'b10);
    end
    idleMasters();
    for (int i = 0; i < RD_LAT + 2; i++) stepCycle(a0, a1);
    checkOutput("m0_rvalid_count", rv0_seen - rv0_before, 16);
    checkOutput("m1_rvalid_count", rv1_seen - rv1_before, 0);

    // Arbitration vector table, starting from a fresh reset.
    applyReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      stepCycle(a0, a1);
      checkOutput($sformatf("vec_ack[%0d]", i), {a0, a1}, {vecs[i].ea0, vecs[i].ea1});
    end
    idleMasters();
    for (int i = 0; i < RD_LAT + 2; i++) stepCycle(a0, a1);

    // Reset while m1's read of addr 5 is in flight.
    rv1_before = rv1_seen;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd5;
    stepCycle(a0, a1);
    checkOutput("mid_rd_ack", {a0, a1}, 2'b01);
    rst = 1'b0;
    idleMasters();
    for (int i = 0; i < RD_LAT + 2; i++) stepCycle(a0, a1);
    checkOutput("no_rvalid_after_rst", rv1_seen - rv1_before, 0);
    rst = 1'b1;
    stepCycle(a0, a1);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd5;
    stepCycle(a0, a1);
    checkOutput("post_rst_rd_ack", {a0, a1}, 2'b01);
    idleMasters();
    for (int i = 0; i < RD_LAT + 2; i++) stepCycle(a0, a1);
    checkOutput("post_rst_rvalid", rv1_seen - rv1_before, 1);
    checkOutput("post_rst_rdata", last_rdata1, 5);

    // Random traffic; each master keeps its command until it is acked.
    a0 = 1'b0; a1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!m0_req || a0) begin
        m0_req   = ($urandom_range(0, 99) < 70);
        m0_we    = 1'($urandom_range(0, 1));
        m0_lock  = 1'($urandom_range(0, 1));
        m0_addr  = AW'($urandom);
        m0_wdata = DW'($urandom);
      end
      if (!m1_req || a1) begin
        m1_req   = ($urandom_range(0, 99) < 70);
        m1_we    = 1'($urandom_range(0, 1));
        m1_lock  = 1'($urandom_range(0, 1));
        m1_addr  = AW'($urandom);
        m1_wdata = DW'($urandom);
      end
      stepCycle(a0, a1);
    end
    idleMasters();
    for (int i = 0; i < RD_LAT + 3; i++) stepCycle(a0, a1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
